// File: rtl/clock_gate_pkg.sv
// -----------------------------------------------------------------------------
// clock_gate_pkg
// Shared types and default constants for the per-domain clock-gating
// controller (clock_gate_ctrl and its per-domain FSM clock_gate_dom_fsm).
//
// Contents:
//   dom_state_t      - per-domain FSM state (OFF, WAKE, ON, IDLE)
//   IDLE_CYCLES_DEF  - default idle threshold before a domain is gated off
//   WAKE_CYCLES_DEF  - default wake latency from gate_en rise to dom_ready rise
//   STAT_W           - width of one per-domain OFF-cycle statistics counter
//                      (only used when CLOCK_GATE_STAT_EN is defined)
// -----------------------------------------------------------------------------
package clock_gate_pkg;

    // OFF  : gating cell disabled, domain clock stopped
    // WAKE : gating cell enabled, waiting for the enable pipeline to settle
    // ON   : clock running, domain active
    // IDLE : clock running, counting consecutive idle cycles
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WAKE = 2'b01,
        ST_ON   = 2'b10,
        ST_IDLE = 2'b11
    } dom_state_t;

    localparam int IDLE_CYCLES_DEF = 16;
    localparam int WAKE_CYCLES_DEF = 2;
    localparam int STAT_W          = 16;

endpackage

// File: rtl/clock_gate_dom_fsm.sv
// -----------------------------------------------------------------------------
// clock_gate_dom_fsm
// One domain of the clock-gating controller: the OFF/WAKE/ON/IDLE FSM, its
// wake and idle counters, and the registered outputs for that domain.
//
// Optional feature (macro CLOCK_GATE_STAT_EN): adds a 16-bit saturating
// counter of cycles spent in OFF, cleared by reset or stat_clr.
//
// Ports:
//   clk       in   system clock (ungated)
//   reset     in   synchronous, active-high reset
//   act       in   activity/request for this domain
//   force_on  in   keep the domain clock enabled
//   force_off in   gate the domain immediately (highest priority)
//   gate_en   out  enable to the gating cell (registered)
//   dom_ready out  domain clock running and stable (registered)
//   dom_gated out  domain is in OFF (registered)
//   stat_clr  in   clear the OFF-cycle counter   (CLOCK_GATE_STAT_EN only)
//   stat_cnt  out  OFF-cycle counter, saturating (CLOCK_GATE_STAT_EN only)
// -----------------------------------------------------------------------------
module clock_gate_dom_fsm
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              act,
    input  logic              force_on,
    input  logic              force_off,
    output logic              gate_en,
    output logic              dom_ready,
    output logic              dom_gated
`ifdef CLOCK_GATE_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_cnt
`endif
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    localparam logic [IW-1:0] IDLE_THR  = IW'(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    dom_state_t    state;
    logic [IW-1:0] idle_cnt;
    logic [WW-1:0] wake_cnt;

    // Domain FSM with registered outputs. The idle counter holds the number
    // of consecutive idle cycles already sampled; the gate drops on the edge
    // that samples the IDLE_CYCLES-th one, so the test against IDLE_LAST is
    // made before the increment. On that edge the counter is loaded with the
    // threshold, which OFF then clears on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_OFF;
            idle_cnt  <= '0;
            wake_cnt  <= '0;
            gate_en   <= 1'b0;
            dom_ready <= 1'b0;
            dom_gated <= 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    idle_cnt <= '0;
                    wake_cnt <= '0;
                    if (!force_off && (force_on || act)) begin
                        state     <= ST_WAKE;
                        gate_en   <= 1'b1;
                        dom_ready <= 1'b0;
                        dom_gated <= 1'b0;
                    end else begin
                        gate_en   <= 1'b0;
                        dom_ready <= 1'b0;
                        dom_gated <= 1'b1;
                    end
                end

                ST_WAKE: begin
                    if (force_off) begin
                        state     <= ST_OFF;
                        wake_cnt  <= '0;
                        gate_en   <= 1'b0;
                        dom_ready <= 1'b0;
                        dom_gated <= 1'b1;
                    end else if (wake_cnt == WAKE_LAST) begin
                        state     <= ST_ON;
                        wake_cnt  <= '0;
                        dom_ready <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + WW'(1);
                    end
                end

                ST_ON: begin
                    if (force_off) begin
                        state     <= ST_OFF;
                        idle_cnt  <= '0;
                        gate_en   <= 1'b0;
                        dom_ready <= 1'b0;
                        dom_gated <= 1'b1;
                    end else if (!act && !force_on) begin
                        // A threshold of one means this first idle cycle
                        // already qualifies, so there is no IDLE dwell.
                        if (IDLE_CYCLES == 1) begin
                            state     <= ST_OFF;
                            idle_cnt  <= IDLE_THR;
                            gate_en   <= 1'b0;
                            dom_ready <= 1'b0;
                            dom_gated <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            idle_cnt <= IW'(1);
                        end
                    end
                end

                ST_IDLE: begin
                    if (force_off) begin
                        state     <= ST_OFF;
                        idle_cnt  <= '0;
                        gate_en   <= 1'b0;
                        dom_ready <= 1'b0;
                        dom_gated <= 1'b1;
                    end else if (act || force_on) begin
                        state    <= ST_ON;
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state     <= ST_OFF;
                        idle_cnt  <= IDLE_THR;
                        gate_en   <= 1'b0;
                        dom_ready <= 1'b0;
                        dom_gated <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end

                default: begin
                    state     <= ST_OFF;
                    idle_cnt  <= '0;
                    wake_cnt  <= '0;
                    gate_en   <= 1'b0;
                    dom_ready <= 1'b0;
                    dom_gated <= 1'b1;
                end
            endcase
        end
    end

`ifdef CLOCK_GATE_STAT_EN
    // Counts cycles the domain sits in OFF; a clear wins over an increment
    // landing on the same edge, and the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_cnt <= '0;
        end else if (state == ST_OFF && stat_cnt != '1) begin
            stat_cnt <= stat_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clock_gate_ctrl
// Per-domain clock-gating controller. Drives the enable of NUM_DOM downstream
// gating cells (posedge flop -> negedge flop -> AND with clk), gating a domain
// off after IDLE_CYCLES idle cycles and reporting dom_ready once the enable
// pipeline has settled after a wake. force_off > force_on > act per domain.
//
// Optional feature (macro CLOCK_GATE_STAT_EN): per-domain 16-bit saturating
// counters of cycles spent in OFF, with a common clear.
//
// Ports:
//   clk       in   1          system clock (ungated)
//   reset     in   1          synchronous, active-high reset
//   act       in   NUM_DOM    per-domain activity/request
//   force_on  in   NUM_DOM    keep domain clock enabled
//   force_off in   NUM_DOM    gate domain immediately
//   gate_en   out  NUM_DOM    gating-cell enable (registered)
//   dom_ready out  NUM_DOM    domain clock running and stable (registered)
//   dom_gated out  NUM_DOM    domain in OFF (registered)
//   stat_clr  in   1          clear all OFF counters      (CLOCK_GATE_STAT_EN)
//   stat_cnt  out  NUM_DOM*16 domain i at [16*i+15:16*i]  (CLOCK_GATE_STAT_EN)
// -----------------------------------------------------------------------------
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int NUM_DOM     = 4,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_DOM-1:0]        act,
    input  logic [NUM_DOM-1:0]        force_on,
    input  logic [NUM_DOM-1:0]        force_off,
    output logic [NUM_DOM-1:0]        gate_en,
    output logic [NUM_DOM-1:0]        dom_ready,
    output logic [NUM_DOM-1:0]        dom_gated
`ifdef CLOCK_GATE_STAT_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_DOM*STAT_W-1:0] stat_cnt
`endif
);

    // Domains are fully independent, so each gets its own FSM instance.
    for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
        clock_gate_dom_fsm #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_fsm (
            .clk       (clk),
            .reset     (reset),
            .act       (act[i]),
            .force_on  (force_on[i]),
            .force_off (force_off[i]),
            .gate_en   (gate_en[i]),
            .dom_ready (dom_ready[i]),
            .dom_gated (dom_gated[i])
`ifdef CLOCK_GATE_STAT_EN
            ,
            .stat_clr  (stat_clr),
            .stat_cnt  (stat_cnt[STAT_W*i +: STAT_W])
`endif
        );
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_gate_ctrl
// Self-checking bench for clock_gate_ctrl (default parameters). A behavioural
// model tracks, per domain, whether it is gated, how many cycles have passed
// since it was enabled, and the length of the current idle run; every cycle
// the DUT outputs are compared against it. Directed scenarios add fixed
// expectations at the key edges. Stat-counter checks are compiled only when
// CLOCK_GATE_STAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_clock_gate_ctrl;

    localparam int ND   = 4;
    localparam int IDLE = 16;
    localparam int WAKE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [ND-1:0] act = '0;
    logic [ND-1:0] force_on = '0;
    logic [ND-1:0] force_off = '0;
    logic [ND-1:0] gate_en;
    logic [ND-1:0] dom_ready;
    logic [ND-1:0] dom_gated;
`ifdef CLOCK_GATE_STAT_EN
    logic             stat_clr = 1'b0;
    logic [ND*16-1:0] stat_cnt;
`endif

    bit clr_next = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    // behavioural model state
    bit m_off [ND];
    int m_age [ND];
    int m_run [ND];
    int m_stat[ND];

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .NUM_DOM     (ND),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .act       (act),
        .force_on  (force_on),
        .force_off (force_off),
        .gate_en   (gate_en),
        .dom_ready (dom_ready),
        .dom_gated (dom_gated)
`ifdef CLOCK_GATE_STAT_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic modelStep(input logic [ND-1:0] a, input logic [ND-1:0] fon,
                             input logic [ND-1:0] foff, input logic rst, input bit clr);
        for (int d = 0; d < ND; d++) begin
            if (rst || clr) m_stat[d] = 0;
            else if (m_off[d] && m_stat[d] < 65535) m_stat[d]++;

            if (rst) begin
                m_off[d] = 1'b1; m_age[d] = 0; m_run[d] = 0;
            end else if (foff[d]) begin
                m_off[d] = 1'b1;
            end else if (m_off[d]) begin
                if (fon[d] || a[d]) begin
                    m_off[d] = 1'b0; m_age[d] = 0; m_run[d] = 0;
                end
            end else if (m_age[d] < WAKE) begin
                m_age[d]++;
            end else if (a[d] || fon[d]) begin
                m_run[d] = 0;
            end else begin
                m_run[d]++;
                if (m_run[d] >= IDLE) m_off[d] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        logic [ND-1:0] eg, er, ed;
        for (int d = 0; d < ND; d++) begin
            eg[d] = !m_off[d];
            er[d] = !m_off[d] && (m_age[d] >= WAKE);
            ed[d] = m_off[d];
        end
        checkVal("gate_en",   32'(gate_en),   32'(eg));
        checkVal("dom_ready", 32'(dom_ready), 32'(er));
        checkVal("dom_gated", 32'(dom_gated), 32'(ed));
`ifdef CLOCK_GATE_STAT_EN
        for (int d = 0; d < ND; d++)
            checkVal("stat_cnt", 32'(stat_cnt[16*d +: 16]), 32'(m_stat[d]));
`endif
    endtask

    // Drive inputs on the falling edge, let the rising edge sample them,
    // update the model, then check 1 time unit later.
    task automatic applyStimulus(input logic [ND-1:0] a, input logic [ND-1:0] fon,
                                 input logic [ND-1:0] foff, input logic rst);
        @(negedge clk);
        act = a; force_on = fon; force_off = foff; reset = rst;
`ifdef CLOCK_GATE_STAT_EN
        stat_clr = clr_next;
`endif
        @(posedge clk);
`ifdef CLOCK_GATE_STAT_EN
        modelStep(a, fon, foff, rst, clr_next);
`else
        modelStep(a, fon, foff, rst, 1'b0);
`endif
        #1;
        edge_n++;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus('0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, 1'b1);
        checkVal("rst_gate_en",   32'(gate_en),   32'h0);
        checkVal("rst_dom_ready", 32'(dom_ready), 32'h0);
        checkVal("rst_dom_gated", 32'(dom_gated), 32'hF);
        edge_n = 0;
    endtask

    initial begin
        logic [ND-1:0] a, fon, foff;
        logic          rst;
        int            act_pct;

        for (int d = 0; d < ND; d++) begin
            m_off[d] = 1'b1; m_age[d] = 0; m_run[d] = 0; m_stat[d] = 0;
        end
        $display("[TB] start");

        // Scenario 1: wake latency on domain 0, idle timeout on domain 1
        doReset();
        for (int n = 1; n <= 40; n++) begin
            a = '0;
            a[0] = (n == 5);
            a[1] = (n >= 10 && n < 20);
            applyStimulus(a, '0, '0, 1'b0);
            if (n == 5) begin
                checkVal("s1_wake_gate0", 32'(gate_en[0]), 32'h1);
                checkVal("s1_others_off", 32'(gate_en[3:1]), 32'h0);
            end
            if (n == 6) checkVal("s1_ready0_early", 32'(dom_ready[0]), 32'h0);
            if (n == 7) checkVal("s1_ready0", 32'(dom_ready[0]), 32'h1);
            if (n == 34) checkVal("s1_gate1_hold", 32'(gate_en[1]), 32'h1);
            if (n == 35) begin
                checkVal("s1_gate1_off", 32'(gate_en[1]), 32'h0);
                checkVal("s1_gated1", 32'(dom_gated[1]), 32'h1);
            end
        end

        // Scenario 2: an act pulse at edge 30 restarts the idle count
        doReset();
        for (int n = 1; n <= 50; n++) begin
            a = '0;
            a[1] = (n >= 10 && n < 20) || (n == 30);
            applyStimulus(a, '0, '0, 1'b0);
            if (n == 35) checkVal("s2_gate1_kept", 32'(gate_en[1]), 32'h1);
            if (n == 45) checkVal("s2_gate1_hold", 32'(gate_en[1]), 32'h1);
            if (n == 46) checkVal("s2_gate1_off", 32'(gate_en[1]), 32'h0);
        end

        // Scenario 3: force_on keeps domain 2 alive with no activity
        doReset();
        for (int n = 1; n <= 120; n++) begin
            fon = '0;
            fon[2] = (n <= 100);
            applyStimulus('0, fon, '0, 1'b0);
            if (n <= 100) checkVal("s3_force_on", 32'(gate_en[2]), 32'h1);
            if (n == 115) checkVal("s3_gate2_hold", 32'(gate_en[2]), 32'h1);
            if (n == 116) checkVal("s3_gate2_off", 32'(gate_en[2]), 32'h0);
        end

        // Scenario 4: force_off beats force_on while waking
        doReset();
        applyStimulus(4'b1000, '0, '0, 1'b0);
        applyStimulus('0, 4'b1000, 4'b1000, 1'b0);
        checkVal("s4_gate3", 32'(gate_en[3]), 32'h0);
        checkVal("s4_ready3", 32'(dom_ready[3]), 32'h0);
        applyStimulus('0, '0, '0, 1'b0);

        // Scenario 5: reset while domains are in mixed states
        doReset();
        for (int n = 1; n <= 5; n++) begin
            a = '0;
            a[0] = 1'b1;
            a[1] = (n == 1);
            a[2] = (n == 4);
            a[3] = (n >= 2);
            applyStimulus(a, '0, '0, 1'b0);
        end
        applyStimulus(4'b1101, '0, '0, 1'b1);
        checkVal("s5_gate_en", 32'(gate_en), 32'h0);
        checkVal("s5_dom_gated", 32'(dom_gated), 32'hF);
        checkVal("s5_dom_ready", 32'(dom_ready), 32'h0);

        // Scenario 6: randomized traffic against the model
        doReset();
        act_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) act_pct = $urandom_range(0, 4) * 25;
            for (int d = 0; d < ND; d++) begin
                a[d]    = ($urandom_range(0, 99) < act_pct);
                fon[d]  = ($urandom_range(0, 99) < 4);
                foff[d] = ($urandom_range(0, 99) < 2);
            end
            rst = ($urandom_range(0, 499) == 0);
            clr_next = ($urandom_range(0, 99) < 3);
            applyStimulus(a, fon, foff, rst);
        end
        clr_next = 1'b0;

`ifdef CLOCK_GATE_STAT_EN
        // Scenario 7: OFF-cycle statistics, clear and saturation
        doReset();
        for (int n = 1; n <= 9; n++) applyStimulus('0, '0, '0, 1'b0);
        applyStimulus(4'b0001, '0, '0, 1'b0);
        applyStimulus(4'b0001, '0, '0, 1'b0);
        checkVal("s7_stat10", 32'(stat_cnt[15:0]), 32'd10);
        clr_next = 1'b1;
        applyStimulus('0, '0, '0, 1'b0);
        clr_next = 1'b0;
        checkVal("s7_stat_clr", 32'(stat_cnt[15:0]), 32'd0);
        for (int n = 0; n < 70000; n++) applyStimulus('0, '0, '0, 1'b0);
        checkVal("s7_stat_sat", 32'(stat_cnt[15:0]), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
